interrupt_ctrl: RTL
===================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 Parameter NUM_INT, default 5, number of interrupt sources (bit 0 = VBlank, 1 = LCDC, 2 = Timer, 3 = Serial, 4 = Joypad); only 5 is supported.
REQ-002 Port clk, input, 1, system clock; all state SHALL update on the rising edge.
REQ-003 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 Port a, input, 16, CPU bus address.
REQ-005 Port din, input, 8, CPU write data.
REQ-006 Port dout, output, 8, CPU read data; combinational.
REQ-007 Port rd, input, 1, CPU read strobe.
REQ-008 Port wr, input, 1, CPU write strobe.
REQ-009 Port int_req, input, 5, peripheral level requests; each is held high until acknowledged.
REQ-010 Port int_ack, output, 5, one-cycle acknowledge pulses to the peripherals.
REQ-011 Port cpu_int, output, 1, registered dispatch request to the CPU.
REQ-012 Port cpu_vector, output, 8, ISR vector; valid while cpu_int is high.
REQ-013 Port cpu_int_ack, input, 1, one-cycle pulse from the CPU accepting the dispatch.

Function
REQ-014 The block SHALL hold IF[4:0] at address 0xFF0F and IE[7:0] at address 0xFFFF.
REQ-015 Reads SHALL be combinational: 0xFF0F returns {3'b111, IF}, 0xFFFF returns IE, and any other address returns 0xFF.
REQ-016 A write with wr=1 to 0xFF0F SHALL load IF from din[4:0]; a write to 0xFFFF SHALL load IE from din.
REQ-017 A per-bit registered copy req_d SHALL be kept; a rising edge (int_req[i]=1, req_d[i]=0) SHALL set IF[i] on that clock edge.
REQ-018 When a rising edge and a clear (write or dispatch) hit IF[i] in the same cycle, the set SHALL win.
REQ-019 When a software write clears IF[i] while int_req[i]=1, int_ack[i] SHALL pulse for exactly one cycle in the following cycle.
REQ-020 The dispatch candidate SHALL be the lowest index i with IF[i] and IE[i] both set; the vector SHALL be 0x40 + 8*i (0x40, 0x48, 0x50, 0x58, 0x60).
REQ-021 The dispatch FSM SHALL have three states: IDLE, PEND and ACK.
REQ-022 In IDLE, if a candidate exists, the FSM SHALL go to PEND, latch the candidate index and cpu_vector, and assert cpu_int on the next cycle.
REQ-023 Latency from the int_req rising edge to cpu_int high SHALL be 2 clocks when the source is already enabled.
REQ-024 In PEND, cpu_vector SHALL stay stable even if a higher-priority source becomes pending; there is no pre-emption.
REQ-025 In PEND, cpu_int_ack=1 SHALL clear IF[latched], drop cpu_int, and move the FSM to ACK.
REQ-026 In ACK, int_ack[latched] SHALL be high for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-027 In PEND, if IF[latched] or IE[latched] is cleared by software, cpu_int SHALL drop and the FSM SHALL return to IDLE with no dispatch ack.
REQ-028 cpu_int_ack received in IDLE or ACK SHALL be ignored.
REQ-029 IE bits 7:5 SHALL be stored and read back but SHALL never produce a dispatch.
REQ-030 At most one int_ack bit SHALL be high in any cycle; a dispatch ack and a software-clear ack in the same cycle SHALL be separated, with the dispatch ack first.

Reset
REQ-031 rst_n=0 SHALL asynchronously set IF=0, IE=0, req_d=0, state=IDLE, cpu_int=0, cpu_vector=0x00 and int_ack=0.
REQ-032 A request held high through reset release SHALL be treated as a rising edge on the first cycle after release.
REQ-033 Reset asserted while in PEND SHALL abort the dispatch and SHALL produce no int_ack.

Structure
REQ-034 Shared package vb_int_pkg SHALL hold the interrupt index constants, the vector base 0x40 and stride 8, the register addresses 0xFF0F and 0xFFFF, and the FSM state enum.
REQ-035 Sub-module int_prio_enc SHALL be combinational: inputs IF&IE[4:0], outputs a valid flag and a 3-bit index.

Verification
REQ-036 IE=0x04, int_req[2] rises -> cpu_int=1 two clocks later with cpu_vector=0x50; cpu_int_ack pulse -> IF reads 0xE0 and int_ack[2] pulses once, one cycle later.
REQ-037 IE=0x1F, int_req[3] and int_req[1] rise in the same cycle -> vector 0x48; after its ack -> vector 0x58.
REQ-038 In PEND on vector 0x60, int_req[0] rises -> cpu_vector stays 0x60 until cpu_int_ack, then 0x40 follows.
REQ-039 IF=0x04 pending, write 0xFF0F=0x00 with int_req[2] high -> cpu_int drops, int_ack[2] pulses once, no dispatch occurs.
REQ-040 Write 0xFF0F=0x00 in the same cycle as an int_req[4] rising edge -> IF reads 0xF0.
REQ-041 Assert rst_n=0 mid-PEND with int_req[1] held high -> outputs are zero immediately; after release, IF reads 0xE2 and IE reads 0x00.

Source files
------------

// File: rtl/vb_int_pkg.sv
// Shared constants for the interrupt controller: source indices, vector layout,
// register addresses and the dispatch FSM state type.
package vb_int_pkg;

  localparam int INT_VBLANK  = 0;
  localparam int INT_LCDC    = 1;
  localparam int INT_TIMER   = 2;
  localparam int INT_SERIAL  = 3;
  localparam int INT_JOYPAD  = 4;
  localparam int NUM_SOURCES = 5;

  localparam logic [7:0]  VEC_BASE   = 8'h40;
  localparam logic [7:0]  VEC_STRIDE = 8'h08;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } disp_state_e;

  function automatic logic [7:0] int_vector(input logic [2:0] idx);
    return VEC_BASE + VEC_STRIDE * {5'b00000, idx};
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit of the enabled-and-pending mask.
module int_prio_enc (
  input  logic [4:0] pend,
  output logic       valid,
  output logic [2:0] idx
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pend[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: IF/IE registers on the CPU bus, edge-detected peripheral
// requests, single-outstanding CPU dispatch and serialized peripheral acknowledges.
module interrupt_ctrl
  import vb_int_pkg::*;
#(
  parameter int NUM_INT = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        a,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  input  logic               rd,
  input  logic               wr,
  input  logic [NUM_INT-1:0] int_req,
  output logic [NUM_INT-1:0] int_ack,
  output logic               cpu_int,
  output logic [7:0]         cpu_vector,
  input  logic               cpu_int_ack
);

  logic [NUM_INT-1:0] if_reg, if_next;
  logic [7:0]         ie_reg, ie_next;
  logic [NUM_INT-1:0] req_d_reg;
  disp_state_e        state_reg, state_next;
  logic [2:0]         idx_reg, idx_next;
  logic [7:0]         vec_reg, vec_next;
  logic               cpu_int_reg, cpu_int_next;
  logic [NUM_INT-1:0] int_ack_reg, int_ack_next;
  logic [NUM_INT-1:0] ack_pend_reg, ack_pend_next;

  logic               wr_if, wr_ie;
  logic [NUM_INT-1:0] rise, if_base, if_sw, sw_clr, avail;
  logic [NUM_INT-1:0] disp_clr, disp_ack;
  logic               cand_valid;
  logic [2:0]         cand_idx;

  assign wr_if   = wr && (a == ADDR_IF);
  assign wr_ie   = wr && (a == ADDR_IE);
  assign rise    = int_req & ~req_d_reg;
  assign if_base = wr_if ? din[NUM_INT-1:0] : if_reg;
  assign ie_next = wr_ie ? din : ie_reg;
  // IF as it will look after this cycle's software write and new edges.
  assign if_sw   = if_base | rise;
  assign sw_clr  = wr_if ? (if_reg & ~din[NUM_INT-1:0] & int_req) : '0;

  int_prio_enc u_prio (
    .pend  (if_reg & ie_reg[NUM_INT-1:0]),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  always_comb begin
    dout = 8'hFF;
    if (rd) begin
      if (a == ADDR_IF)      dout = {{(8-NUM_INT){1'b1}}, if_reg};
      else if (a == ADDR_IE) dout = ie_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    vec_next   = vec_reg;
    disp_clr   = '0;
    disp_ack   = '0;
    case (state_reg)
      ST_IDLE: begin
        // Skip a candidate that software is clearing in this very cycle.
        if (cand_valid && if_sw[cand_idx] && ie_next[cand_idx]) begin
          state_next = ST_PEND;
          idx_next   = cand_idx;
          vec_next   = int_vector(cand_idx);
        end
      end
      ST_PEND: begin
        if (cpu_int_ack) begin
          state_next         = ST_ACK;
          disp_clr[idx_reg]  = 1'b1;
          disp_ack[idx_reg]  = 1'b1;
        end else if (!(if_sw[idx_reg] && ie_next[idx_reg])) begin
          state_next = ST_IDLE;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign if_next      = (if_base & ~disp_clr) | rise;
  assign cpu_int_next = (state_next == ST_PEND);

  // Dispatch ack takes the slot; software-clear acks wait, lowest index first.
  always_comb begin
    avail = ack_pend_reg | sw_clr;
    if (|disp_ack) begin
      int_ack_next  = disp_ack;
      ack_pend_next = avail & ~disp_ack;
    end else begin
      int_ack_next  = avail & (-avail);
      ack_pend_next = avail & ~int_ack_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_reg       <= '0;
      ie_reg       <= 8'h00;
      req_d_reg    <= '0;
      state_reg    <= ST_IDLE;
      idx_reg      <= 3'd0;
      vec_reg      <= 8'h00;
      cpu_int_reg  <= 1'b0;
      int_ack_reg  <= '0;
      ack_pend_reg <= '0;
    end else begin
      if_reg       <= if_next;
      ie_reg       <= ie_next;
      req_d_reg    <= int_req;
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      vec_reg      <= vec_next;
      cpu_int_reg  <= cpu_int_next;
      int_ack_reg  <= int_ack_next;
      ack_pend_reg <= ack_pend_next;
    end
  end

  assign cpu_int    = cpu_int_reg;
  assign cpu_vector = vec_reg;
  assign int_ack    = int_ack_reg;

endmodule
